// File: rtl/lane_delay_model.sv
// Per-lane settle-time model: delays rise/fall of in_sig by programmable cycle counts and
// filters shorter pulses. Define LDM_STICKY_EN to make HIGH terminal (only clr/rst clear it).
module lane_delay_model #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned RISE_RST = 1000,
  parameter int unsigned FALL_RST = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic [LANES-1:0]                      in_sig,
  input  logic                                  cfg_we,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] cfg_lane,
  input  logic [CNT_W-1:0]                      cfg_rise,
  input  logic [CNT_W-1:0]                      cfg_fall,
  output logic [LANES-1:0]                      out_sig,
  output logic [LANES-1:0]                      busy,
  output logic [LANES-1:0]                      edge_evt
);

  localparam int LN_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_WAIT = 2'd3;

  logic [1:0]       st     [LANES];
  logic [1:0]       st_nx  [LANES];
  logic [CNT_W-1:0] cnt    [LANES];
  logic [CNT_W-1:0] cnt_nx [LANES];
  logic [CNT_W-1:0] rise_r [LANES];
  logic [CNT_W-1:0] fall_r [LANES];
  logic [LANES-1:0] out_nx;
  logic [LANES-1:0] busy_nx;

  // Delay regs are read before this edge's config write lands, so a wait
  // starting on the same edge as a write uses the old value.
  always_comb begin
    out_nx  = '0;
    busy_nx = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      st_nx[i]  = st[i];
      cnt_nx[i] = cnt[i];
      if (clr) begin
        st_nx[i]  = ST_LOW;
        cnt_nx[i] = '0;
      end else begin
        case (st[i])
          ST_LOW: begin
            if (in_sig[i]) begin
              if (rise_r[i] == '0) begin
                st_nx[i] = ST_HIGH;
              end else begin
                st_nx[i]  = ST_RISE_WAIT;
                cnt_nx[i] = rise_r[i] - CNT_W'(1);
              end
            end
          end
          ST_RISE_WAIT: begin
            if (!in_sig[i]) begin
              st_nx[i]  = ST_LOW;
              cnt_nx[i] = '0;
            end else if (cnt[i] == '0) begin
              st_nx[i] = ST_HIGH;
            end else begin
              cnt_nx[i] = cnt[i] - CNT_W'(1);
            end
          end
          ST_HIGH: begin
`ifdef LDM_STICKY_EN
            st_nx[i] = ST_HIGH;
`else
            if (!in_sig[i]) begin
              if (fall_r[i] == '0) begin
                st_nx[i] = ST_LOW;
              end else begin
                st_nx[i]  = ST_FALL_WAIT;
                cnt_nx[i] = fall_r[i] - CNT_W'(1);
              end
            end
`endif
          end
          ST_FALL_WAIT: begin
            if (in_sig[i]) begin
              st_nx[i]  = ST_HIGH;
              cnt_nx[i] = '0;
            end else if (cnt[i] == '0) begin
              st_nx[i] = ST_LOW;
            end else begin
              cnt_nx[i] = cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            st_nx[i]  = ST_LOW;
            cnt_nx[i] = '0;
          end
        endcase
      end
      out_nx[i]  = (st_nx[i] == ST_HIGH) || (st_nx[i] == ST_FALL_WAIT);
      busy_nx[i] = (st_nx[i] == ST_RISE_WAIT) || (st_nx[i] == ST_FALL_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        st[i]     <= ST_LOW;
        cnt[i]    <= '0;
        rise_r[i] <= CNT_W'(RISE_RST);
        fall_r[i] <= CNT_W'(FALL_RST);
      end
      out_sig  <= '0;
      busy     <= '0;
      edge_evt <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        st[i]  <= st_nx[i];
        cnt[i] <= cnt_nx[i];
        // Out-of-range lane indices match no lane and are dropped.
        if (cfg_we && (cfg_lane == LN_W'(i))) begin
          rise_r[i] <= cfg_rise;
          fall_r[i] <= cfg_fall;
        end
      end
      out_sig  <= out_nx;
      busy     <= busy_nx;
      edge_evt <= out_nx ^ out_sig;
    end
  end

endmodule
